// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit-period width.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START_BIT  = 3'd1,
        S_DATA_BITS  = 3'd2,
        S_PARITY_BIT = 3'd3,
        S_STOP_BIT   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int CPB_WIDTH = 13;
    localparam logic [CPB_WIDTH-1:0] CPB_MIN = 13'd2;

    function automatic logic [CPB_WIDTH-1:0] clamp_cpb(
        input logic [CPB_WIDTH-1:0] cpb
    );
        return (cpb < CPB_MIN) ? CPB_MIN : cpb;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: latches the period at load, counts 0..period-1 and
// strobes at terminal count while the engine is running.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_run,
    input  logic [CPB_WIDTH-1:0] i_cpb,
    output logic                 o_tc
);

    logic [CPB_WIDTH-1:0] r_period;
    logic [CPB_WIDTH-1:0] r_cnt;
    logic                 w_last;

    assign w_last = (r_cnt == r_period - 1'b1);
    assign o_tc   = i_run & w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period <= CPB_MIN;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_period <= clamp_cpb(i_cpb);
            r_cnt    <= '0;
        end else if (i_run) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input, one-entry hold register,
// LSB-first framing with optional parity and 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int data_width = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CPB_WIDTH-1:0]  CLKS_PER_BIT,
    input  logic [data_width-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  busy,
    output logic                  done
);

    uart_state_e r_state, w_state_nxt;

    logic [data_width-1:0] r_shift, w_shift_nxt;
    logic [data_width-1:0] r_hold;
    logic                  r_par, w_par_nxt;
    logic                  r_hold_par;
    logic                  r_hold_full;
    logic [3:0]            r_bit_cnt, w_bit_cnt_nxt;
    logic                  r_stop_cnt, w_stop_cnt_nxt;
    logic                  r_tx_serial, w_serial_nxt;
    logic                  r_done, w_done_nxt;

    logic w_accept;
    logic w_load_in;
    logic w_load_hold;
    logic w_load;
    logic w_tc;
    logic w_in_par;
    logic w_run;

    assign w_accept  = tx_valid & ~r_hold_full;
    assign w_in_par  = (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;
    assign w_load    = w_load_in | w_load_hold;
    assign w_run     = (r_state != S_IDLE);

    assign tx_ready  = ~r_hold_full;
    assign tx_serial = r_tx_serial;
    assign busy      = w_run;
    assign done      = r_done;

    uart_bit_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_run  (w_run),
        .i_cpb  (CLKS_PER_BIT),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_par_nxt      = r_par;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_load_in      = 1'b0;
        w_load_hold    = 1'b0;
        w_done_nxt     = 1'b0;
        w_serial_nxt   = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_accept) w_load_in = 1'b1;
            end
            S_START_BIT: begin
                if (w_tc) w_state_nxt = S_DATA_BITS;
            end
            S_DATA_BITS: begin
                if (w_tc) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == 4'(data_width - 1)) begin
                        w_bit_cnt_nxt  = '0;
                        w_stop_cnt_nxt = 1'b0;
                        w_state_nxt    = (PARITY != PARITY_NONE) ?
                                         S_PARITY_BIT : S_STOP_BIT;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
            end
            S_PARITY_BIT: begin
                if (w_tc) begin
                    w_state_nxt    = S_STOP_BIT;
                    w_stop_cnt_nxt = 1'b0;
                end
            end
            S_STOP_BIT: begin
                if (w_tc) begin
                    if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        w_done_nxt = 1'b1;
                        if (r_hold_full)   w_load_hold = 1'b1;
                        else if (w_accept) w_load_in   = 1'b1;
                        else               w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A pending hold word always wins over a fresh offer.
        if (w_load_hold) begin
            w_shift_nxt = r_hold;
            w_par_nxt   = r_hold_par;
        end else if (w_load_in) begin
            w_shift_nxt = tx_data;
            w_par_nxt   = w_in_par;
        end
        if (w_load) begin
            w_state_nxt    = S_START_BIT;
            w_bit_cnt_nxt  = '0;
            w_stop_cnt_nxt = 1'b0;
        end

        case (w_state_nxt)
            S_START_BIT:  w_serial_nxt = 1'b0;
            S_DATA_BITS:  w_serial_nxt = w_shift_nxt[0];
            S_PARITY_BIT: w_serial_nxt = w_par_nxt;
            default:      w_serial_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_tx_serial <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_par       <= w_par_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_stop_cnt  <= w_stop_cnt_nxt;
            r_tx_serial <= w_serial_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_par  <= 1'b0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_load_hold) r_hold_full <= 1'b0;
            if (w_accept && !w_load_in) begin
                r_hold      <= tx_data;
                r_hold_par  <= w_in_par;
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized bench for uart_tx against a frame-level model
// (8N1, 8E2 and 8O1 instances).
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] cpb;
    logic [7:0]  tx_data;
    logic        v0, v1, v2;
    logic        rdy0, ser0, bsy0, dn0;
    logic        rdy1, ser1, bsy1, dn1;
    logic        rdy2, ser2, bsy2, dn2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx #(.data_width(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .CLKS_PER_BIT(cpb), .tx_data(tx_data),
        .tx_valid(v0), .tx_ready(rdy0), .tx_serial(ser0),
        .busy(bsy0), .done(dn0)
    );
    uart_tx #(.data_width(8), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .CLKS_PER_BIT(cpb), .tx_data(tx_data),
        .tx_valid(v1), .tx_ready(rdy1), .tx_serial(ser1),
        .busy(bsy1), .done(dn1)
    );
    uart_tx #(.data_width(8), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .CLKS_PER_BIT(cpb), .tx_data(tx_data),
        .tx_valid(v2), .tx_ready(rdy2), .tx_serial(ser2),
        .busy(bsy2), .done(dn2)
    );

    function automatic int pmode(input int idx);
        return (idx == 0) ? 0 : (idx == 1) ? 1 : 2;
    endfunction

    function automatic int nstop(input int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    function automatic int eff_cpb(input int c);
        return (c < 2) ? 2 : c;
    endfunction

    function automatic int frame_len(input int idx, input int c);
        return (1 + 8 + ((pmode(idx) != 0) ? 1 : 0) + nstop(idx)) * eff_cpb(c);
    endfunction

    // Expected line level at cycle t of a frame started at cycle 0.
    function automatic logic exp_bit(input int idx, input logic [7:0] d,
                                     input int c, input int t);
        int b;
        b = t / eff_cpb(c);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        b = b - 9;
        if (pmode(idx) != 0) begin
            if (b == 0) return (pmode(idx) == 1) ? ^d : ~^d;
        end
        return 1'b1;
    endfunction

    function automatic logic [3:0] outs(input int idx);
        case (idx)
            0:       return {ser0, rdy0, bsy0, dn0};
            1:       return {ser1, rdy1, bsy1, dn1};
            default: return {ser2, rdy2, bsy2, dn2};
        endcase
    endfunction

    task automatic set_valid(input int idx, input logic v);
        case (idx)
            0:       v0 = v;
            1:       v1 = v;
            default: v2 = v;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string nm, input int idx, input int t,
                               input logic es, input logic er,
                               input logic eb, input logic ed);
        logic [3:0] o;
        o = outs(idx);
        chk($sformatf("%s d%0d t%0d serial", nm, idx, t), 32'(o[3]), 32'(es));
        chk($sformatf("%s d%0d t%0d ready", nm, idx, t), 32'(o[2]), 32'(er));
        chk($sformatf("%s d%0d t%0d busy", nm, idx, t), 32'(o[1]), 32'(eb));
        chk($sformatf("%s d%0d t%0d done", nm, idx, t), 32'(o[0]), 32'(ed));
    endtask

    task automatic run_frame(input string nm, input int idx,
                             input logic [7:0] d, input int c0, input int c1);
        int n;
        n = frame_len(idx, c0);
        @(negedge clk);
        cpb     = 13'(c0);
        tx_data = d;
        set_valid(idx, 1'b1);
        for (int t = 0; t <= n; t++) begin
            @(negedge clk);
            if (t == 0) set_valid(idx, 1'b0);
            if (t == 10) cpb = 13'(c1);
            check_cycle(nm, idx, t, (t < n) ? exp_bit(idx, d, c0, t) : 1'b1,
                        1'b1, t < n, t == n);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         ri;
        int         rc;

        rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        tx_data = 8'h00;
        cpb = 13'd4;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check_cycle("reset", i, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        run_frame("8N1_A5", 0, 8'hA5, 4, 4);
        run_frame("8E2_07", 1, 8'h07, 4, 4);
        run_frame("8O1_07", 2, 8'h07, 4, 4);

        // Back-to-back 0x00 then 0xFF with tx_valid held high.
        @(negedge clk);
        cpb = 13'd4;
        tx_data = 8'h00;
        v0 = 1'b1;
        for (int t = 0; t <= 80; t++) begin
            @(negedge clk);
            check_cycle("b2b", 0, t,
                (t < 40) ? exp_bit(0, 8'h00, 4, t) :
                (t < 80) ? exp_bit(0, 8'hFF, 4, t - 40) : 1'b1,
                !(t >= 1 && t < 40), t < 80, (t == 40) || (t == 80));
            if (t == 0) tx_data = 8'hFF;
            if (t == 1) v0 = 1'b0;
        end

        // Period change mid-frame, then the new period, then clamp.
        run_frame("cpb_mid", 0, 8'h96, 4, 8);
        run_frame("cpb_8", 0, 8'h3B, 8, 8);
        run_frame("cpb_1", 0, 8'hC4, 1, 1);

        for (int i = 0; i < 6; i++) begin
            ri = int'($urandom_range(0, 2));
            rd = 8'($urandom);
            rc = int'($urandom_range(0, 6));
            run_frame("rand", ri, rd, rc, rc);
        end

        // Reset during DATA_BITS with the hold register full.
        @(negedge clk);
        cpb = 13'd4;
        tx_data = 8'h5A;
        v0 = 1'b1;
        @(negedge clk);
        tx_data = 8'hC3;
        @(negedge clk);
        v0 = 1'b0;
        chk("rst hold full ready", 32'(rdy0), 32'd0);
        repeat (14) @(negedge clk);
        chk("rst pre busy", 32'(bsy0), 32'd1);
        rst = 1'b0;
        #1;
        check_cycle("rst_now", 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            check_cycle("rst_hold", 0, t, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        rst = 1'b1;
        run_frame("after_rst_3C", 0, 8'h3C, 4, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
